// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a byte FIFO.
// Stores to TXDATA queue bytes; STATUS exposes FIFO and line state.
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADR     = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_adr,
  input  logic        write_enable,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        sel,
  output logic        tx
);

  localparam int unsigned PW =
    (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] OFS_TXDATA = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        state;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic [BW-1:0] baud;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic [1:0]    ofs;
  logic          wr_txdata;
  logic          wr_status;
  logic          full;
  logic          empty;
  logic          busy;
  logic          push;
  logic          pop;
  logic [4:0]    cnt5;
  logic [31:0]   status;
  logic          unused_ok;

  // Address decode and register-level strobes.
  assign ofs       = data_adr[3:2];
  assign sel       = (data_adr[31:4] == BASE_ADR[31:4]);
  assign wr_txdata = sel & write_enable & (ofs == OFS_TXDATA);
  assign wr_status = sel & write_enable & (ofs == OFS_STATUS);

  // FIFO flags use pre-edge state, so a full push is
  // dropped even when the FSM pops on the same edge.
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign busy  = (state != S_IDLE);
  assign push  = wr_txdata & ~full;
  assign pop   = (state == S_IDLE) & ~empty;

  assign cnt5   = 5'(count);
  assign status = {19'd0, cnt5, 4'd0,
                   overflow, busy, empty, full};

  assign unused_ok = ^{data_adr[1:0], WriteData[31:8]};

  // Register read mux; anything but STATUS reads as zero.
  always_comb begin
    ReadData = '0;
    if (sel && ofs == OFS_STATUS) begin
      ReadData = status;
    end
  end

  // FIFO storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= WriteData[7:0];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case (1'b1)
        (push & ~pop): count <= count + CW'(1);
        (pop & ~push): count <= count - CW'(1);
        default:       count <= count;
      endcase
    end
  end

  // Sticky overflow, set by a push into a full FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wr_txdata & full) begin
      overflow <= 1'b1;
    end else if (wr_status & WriteData[3]) begin
      overflow <= 1'b0;
    end
  end

  // Frame FSM; tx is registered so the line never glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      shift   <= '0;
      bit_idx <= '0;
      baud    <= '0;
      tx      <= 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            shift   <= mem[rd_ptr];
            bit_idx <= '0;
            baud    <= '0;
            tx      <= 1'b0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (baud == BAUD_MAX) begin
            baud  <= '0;
            tx    <= shift[0];
            state <= S_DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        S_DATA: begin
          if (baud == BAUD_MAX) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              shift   <= {1'b0, shift[7:1]};
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        S_STOP: begin
          tx <= 1'b1;
          if (baud == BAUD_MAX) begin
            baud  <= '0;
            state <= S_IDLE;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench for the MMIO UART transmitter.
// Per-cycle line model plus a serial decoder feeding a byte queue.
module tb_mmio_uart_tx;

  localparam int          CPB  = 4;
  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] TXD  = BASE;
  localparam logic [31:0] STA  = BASE + 32'h4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_adr;
  logic        write_enable;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        sel;
  logic        tx;

  int checks = 0;
  int errors = 0;
  int stop_bad = 0;
  int lows;
  logic [31:0] d;
  logic [7:0]  rx_q [$];
  bit          rst_seen = 1'b0;

  mmio_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(8),
    .BASE_ADR(BASE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .data_adr(data_adr),
    .write_enable(write_enable),
    .WriteData(WriteData),
    .ReadData(ReadData),
    .sel(sel),
    .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a,
                       input logic [31:0] v);
    @(negedge clk);
    data_adr     = a;
    WriteData    = v;
    write_enable = 1'b1;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    data_adr     = '0;
    WriteData    = '0;
  endtask

  task automatic rd(input logic [31:0] a,
                    output logic [31:0] v);
    data_adr = a;
    #1;
    v = ReadData;
  endtask

  // Expected line level at cycle idx (0..9) of a frame.
  function automatic logic frame_bit(input logic [7:0] b,
                                     input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  // Line model for three frames starting after edges 1, 42, 83.
  function automatic logic exp_tx3(input int n);
    logic [7:0] bs [3];
    int ss [3];
    bs = '{8'h55, 8'h01, 8'h80};
    ss = '{1, 42, 83};
    for (int f = 0; f < 3; f++) begin
      if (n >= ss[f] && n < ss[f] + 10 * CPB)
        return frame_bit(bs[f], (n - ss[f]) / CPB);
    end
    return 1'b1;
  endfunction

  always @(posedge reset) rst_seen = 1'b1;

  // Serial decoder: samples each bit mid-way.
  always begin : rx_mon
    logic [7:0] b;
    @(posedge clk);
    #1;
    if (reset === 1'b0 && tx === 1'b0) begin
      rst_seen = 1'b0;
      b = '0;
      repeat (CPB + 1) @(posedge clk);
      #1 b[0] = tx;
      for (int i = 1; i < 8; i++) begin
        repeat (CPB) @(posedge clk);
        #1 b[i] = tx;
      end
      repeat (CPB) @(posedge clk);
      #1;
      if (!rst_seen) begin
        rx_q.push_back(b);
        if (tx !== 1'b1) stop_bad++;
      end
    end
  end

  initial begin
    reset        = 1'b1;
    data_adr     = '0;
    write_enable = 1'b0;
    WriteData    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;

    chk("rst_tx", 32'(tx), 32'd1);
    rd(STA, d);
    chk("rst_status", d, 32'h0000_0002);
    chk("sel_base4", 32'(sel), 32'd1);
    rd(32'h0000_0100, d);
    chk("sel_out", 32'(sel), 32'd0);
    chk("rd_out", d, 32'h0);
    rd(TXD, d);
    chk("rd_txdata", d, 32'h0);

    store(32'h0000_0000, 32'h0000_0077);
    store(BASE + 32'h8, 32'h0000_0055);
    repeat (3) @(posedge clk);
    #1;
    rd(STA, d);
    chk("nosel_status", d, 32'h0000_0002);
    chk("nosel_tx", 32'(tx), 32'd1);

    store(TXD, 32'h0000_00A5);
    chk("a5_pre_tx", 32'(tx), 32'd1);
    data_adr = STA;
    for (int n = 1; n <= 41; n++) begin
      @(posedge clk);
      #1;
      chk($sformatf("a5_tx_%0d", n), 32'(tx),
          (n <= 40) ? 32'(frame_bit(8'hA5, (n-1)/CPB))
                    : 32'd1);
      chk($sformatf("a5_busy_%0d", n), 32'(ReadData[2]),
          (n <= 40) ? 32'd1 : 32'd0);
    end
    chk("a5_rxn", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() == 1)
      chk("a5_rxb", 32'(rx_q[0]), 32'h0000_00A5);
    rx_q.delete();

    for (int i = 0; i < 9; i++)
      store(TXD, 32'(8'h10 + i));
    rd(STA, d);
    chk("fill9_status", d, 32'h0000_0805);
    store(TXD, 32'h0000_0019);
    rd(STA, d);
    chk("ovf_status", d, 32'h0000_080D);
    store(STA, 32'h0000_0007);
    rd(STA, d);
    chk("ovf_keep", d, 32'h0000_080D);
    store(STA, 32'h0000_0008);
    rd(STA, d);
    chk("ovf_clear", d, 32'h0000_0805);
    store(BASE + 32'h8, 32'hFFFF_FFFF);
    store(32'h0000_0000, 32'h0000_0042);
    rd(BASE + 32'h7, d);
    chk("status_lowbits", d, 32'h0000_0805);
    rd(BASE + 32'hC, d);
    chk("rd_c", d, 32'h0);
    for (int i = 0; i < 800 && rx_q.size() < 9; i++)
      @(posedge clk);
    repeat (100) @(posedge clk);
    #1;
    chk("fill_rxn", 32'(rx_q.size()), 32'd9);
    for (int i = 0; i < 9 && i < rx_q.size(); i++)
      chk($sformatf("fill_rx_%0d", i), 32'(rx_q[i]),
          32'(8'h10 + i));
    rd(STA, d);
    chk("fill_drained", d, 32'h0000_0002);
    rx_q.delete();

    store(TXD, 32'h0000_0055);
    store(TXD, 32'h0000_0001);
    store(TXD, 32'h0000_0080);
    rd(STA, d);
    chk("two_cnt_2", 32'(d[12:8]), 32'd2);
    for (int n = 3; n <= 126; n++) begin
      @(posedge clk);
      #1;
      chk($sformatf("two_tx_%0d", n), 32'(tx),
          32'(exp_tx3(n)));
      chk($sformatf("two_cnt_%0d", n), 32'(ReadData[12:8]),
          (n < 42) ? 32'd2 : (n < 83) ? 32'd1 : 32'd0);
    end
    chk("two_rxn", 32'(rx_q.size()), 32'd3);
    if (rx_q.size() == 3) begin
      chk("two_rx0", 32'(rx_q[0]), 32'h55);
      chk("two_rx1", 32'(rx_q[1]), 32'h01);
      chk("two_rx2", 32'(rx_q[2]), 32'h80);
    end
    rx_q.delete();

    store(TXD, 32'h0000_003C);
    @(posedge clk);
    #1;
    chk("rsta_start", 32'(tx), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rsta_tx", 32'(tx), 32'd1);
    rd(STA, d);
    chk("rsta_status", d, 32'h0000_0002);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("rsta_idle", 32'(tx), 32'd1);
    chk("rsta_rxn", 32'(rx_q.size()), 32'd0);

    store(TXD, 32'h0000_00FF);
    store(TXD, 32'h0000_0011);
    store(TXD, 32'h0000_0022);
    store(TXD, 32'h0000_0033);
    repeat (8) @(posedge clk);
    #1;
    rd(STA, d);
    chk("rstb_pre", d, 32'h0000_0304);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstb_tx", 32'(tx), 32'd1);
    rd(STA, d);
    chk("rstb_status", d, 32'h0000_0002);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    rd(STA, d);
    chk("rstb_release", d, 32'h0000_0002);
    lows = 0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1) lows++;
    end
    chk("rstb_lows", 32'(lows), 32'd0);
    chk("rstb_rxn", 32'(rx_q.size()), 32'd0);
    chk("stop_bits", 32'(stop_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the multicycle RISC-V core's data bus, in parallel with the unified memory.
- Consumes processor stores to its address window: bytes are queued in a FIFO and serialised as 8N1 frames on `tx`.
- Exposes a status word for software polling.
- Top level uses `sel` to steer ReadData between this block and memory, and to gate memory write_enable.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit; must be ≥2.
- FIFO_DEPTH, 8: transmit FIFO entries; power of two, 2..16.
- BASE_ADR, 32'hFFFF_0000: window base; 16-byte aligned.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_adr  in  32  byte address from processor.
- write_enable  in  1  store strobe from processor.
- WriteData  in  32  store data.
- ReadData  out  32  register read data; combinational from data_adr.
- sel  out  1  high when data_adr[31:4] == BASE_ADR[31:4]; combinational.
- tx  out  1  serial output, idle high.

Behaviour:
- Register map (word offsets; data_adr[1:0] ignored):
  - +0x0 TXDATA: write pushes WriteData[7:0]; reads 0.
  - +0x4 STATUS: read [0]=full, [1]=empty, [2]=busy, [3]=overflow (sticky), [8+:5]=fifo count, other bits 0. Writing with WriteData[3]=1 clears overflow; other bits ignored.
  - +0x8, +0xC: read 0, writes ignored.
- ReadData is 0 when sel=0.
- Push occurs on a clock edge with sel & write_enable & offset 0.
- Push while full, judged by pre-edge state:
  - byte dropped and overflow set;
  - applies even if a pop happens on the same edge.
- Push and pop on the same edge, not full: count unchanged, both operations take effect.
- FIFO storage: circular, wr_ptr/rd_ptr wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- Transmit FSM states IDLE, START, DATA, STOP:
  - IDLE: tx=1. If FIFO non-empty, pop the head into an 8-bit shift register, clear the bit counter and baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shift[0] (LSB first). Each CLKS_PER_BIT cycles, shift right and increment the bit index; after the 8th bit go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- tx is driven from a register, so it is glitch-free.
- busy = (state != IDLE).
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Latency: a push on edge k makes tx go low after edge k+1 if the FSM was IDLE with the FIFO empty.
- Back-to-back frames: STOP→IDLE takes one cycle; IDLE pops immediately, so the inter-frame idle is 1 cycle.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps; it is reset on every state entry.
- Reset (asynchronous, any time including mid-frame):
  - state=IDLE, tx=1, FIFO emptied (pointers and count 0), overflow=0, counters 0.
  - ReadData reflects the cleared state immediately.
- Writes with sel=0 have no effect; reads with sel=0 return 0.

Test Plan:
- Reset release, no stimulus → tx=1; STATUS reads 0x0000_0002 (empty); sel=0 for address 0x0000_0100.
- CLKS_PER_BIT=4: store 0x000000A5 to BASE+0 → tx sequence 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles. Start bit begins 1 cycle after the store edge; busy=1 for 40 cycles.
- Store 9 bytes on consecutive cycles while the FSM is idle → first byte popped after edge 1. The 9th store is accepted (count was 7) and overflow stays 0; an additional 10th store at full sets STATUS[3]=1 and the byte never appears on tx.
- Write 0x8 to BASE+4 after overflow → STATUS[3]=0; other status bits unchanged.
- Two bytes 0x01, 0x80 queued → two frames separated by exactly 1 idle-high cycle; STATUS count decrements 2→1→0 at each pop.
- Assert reset mid-DATA of byte 0xFF with 3 bytes queued → tx=1 immediately (asynchronous); STATUS=0x0000_0002 after release; no further frames transmitted.
